// File: rtl/nand_cpu_sequencer_if.sv
// RAM request/acknowledge bus between the Nandgame CPU sequencer and its data memory.
interface nand_cpu_sequencer_if;
  logic        ram_req;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ack;

  modport master (
    output ram_req,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ack
  );

  modport slave (
    input  ram_req,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ack
  );
endinterface

// File: rtl/nand_cpu_sequencer.sv
// Multi-cycle sequencer for the Nandgame CPU: owns A/D/PC, fetches from ROM, reads and
// writes RAM at A over a req/ack bus, and commits the external control unit's results.
module nand_cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [15:0]          rom_addr,
  input  logic [15:0]          rom_data,
  nand_cpu_sequencer_if.master ram,
  output logic [15:0]          cu_I,
  output logic [15:0]          cu_A,
  output logic [15:0]          cu_D,
  output logic [15:0]          cu_addrA,
  input  logic [15:0]          cu_R,
  input  logic                 cu_a,
  input  logic                 cu_d,
  input  logic                 cu_addr_a,
  input  logic                 cu_j,
  output logic [15:0]          pc,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          retired
);

  typedef enum logic [2:0] {StIdle, StFetch, StRead, StExec, StWrite, StHalt} state_e;

  localparam logic [15:0] LastWait = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] a_q, d_q, ir_q, mr_q, pc_q, retired_q, rlat_q, wait_q;
  logic        lat_a_q, lat_d_q, lat_j_q, err_q;
  logic        commit, timeout, in_xfer, in_write;
  logic [15:0] res;
  logic        en_a, en_d, en_j;

  assign in_xfer  = (state_q == StRead) || (state_q == StWrite);
  assign in_write = (state_q == StWrite);

  // A store commits from values latched in EXEC; everything else commits live CU outputs.
  assign res  = in_write ? rlat_q  : cu_R;
  assign en_a = in_write ? lat_a_q : cu_a;
  assign en_d = in_write ? lat_d_q : cu_d;
  assign en_j = in_write ? lat_j_q : cu_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StIdle:  if (run) state_d = StFetch;
      StFetch: state_d = rom_data[15] ? StRead : StExec;
      StRead: begin
        if (ram.ram_ack) begin
          state_d = StExec;
        end else if (wait_q == LastWait) begin
          timeout = 1'b1;
          state_d = StHalt;
        end
      end
      StExec: begin
        if (cu_addr_a) state_d = StWrite;
        else           commit  = 1'b1;
      end
      StWrite: begin
        if (ram.ram_ack) begin
          commit = 1'b1;
        end else if (wait_q == LastWait) begin
          timeout = 1'b1;
          state_d = StHalt;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (commit) state_d = run ? StFetch : StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      d_q       <= '0;
      ir_q      <= '0;
      mr_q      <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      rlat_q    <= '0;
      lat_a_q   <= 1'b0;
      lat_d_q   <= 1'b0;
      lat_j_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      wait_q <= in_xfer ? wait_q + 16'd1 : 16'd0;
      if (state_q == StFetch) ir_q <= rom_data;
      if ((state_q == StRead) && ram.ram_ack) mr_q <= ram.ram_rdata;
      if ((state_q == StExec) && cu_addr_a) begin
        rlat_q  <= cu_R;
        lat_a_q <= cu_a;
        lat_d_q <= cu_d;
        lat_j_q <= cu_j;
      end
      if (commit) begin
        if (en_a) a_q <= res;
        if (en_d) d_q <= res;
        pc_q      <= en_j ? a_q : pc_q + 16'd1;
        retired_q <= retired_q + 16'd1;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  // A is untouched during READ/WRITE, so it can drive the address directly.
  always_comb begin
    busy          = (state_q != StIdle) && (state_q != StHalt);
    ram.ram_req   = in_xfer;
    ram.ram_we    = in_write;
    ram.ram_addr  = in_xfer ? a_q : 16'h0000;
    ram.ram_wdata = in_write ? rlat_q : 16'h0000;
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign cu_I     = ir_q;
  assign cu_A     = a_q;
  assign cu_D     = d_q;
  assign cu_addrA = mr_q;
  assign retired  = retired_q;
  assign err      = err_q;

endmodule

// File: tb/tb_nand_cpu_sequencer.sv
// Directed bench for nand_cpu_sequencer: a default instance plus one with RESET_PC=FFFF and
// ACK_TIMEOUT=4, sharing run/ROM/control-unit stimulus but each with its own RAM bus.
module tb_nand_cpu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, run;
  logic [15:0] rom_data, cu_R;
  logic        cu_a, cu_d, cu_addr_a, cu_j;

  logic [15:0] rom_addr, cu_I, cu_A, cu_D, cu_addrA, pc, retired;
  logic        busy, err;
  logic [15:0] w_rom_addr, w_cu_I, w_cu_A, w_cu_D, w_cu_addrA, w_pc, w_retired;
  logic        w_busy, w_err;

  int checks = 0;
  int passes = 0;
  int req_cyc = 0;
  int busy_cyc = 0;
  int w_req_cyc = 0;

  nand_cpu_sequencer_if ram_if ();
  nand_cpu_sequencer_if w_ram_if ();

  always #5 clk = ~clk;

  nand_cpu_sequencer #(.RESET_PC(16'h0000), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram(ram_if), .cu_I(cu_I), .cu_A(cu_A), .cu_D(cu_D), .cu_addrA(cu_addrA), .cu_R(cu_R),
    .cu_a(cu_a), .cu_d(cu_d), .cu_addr_a(cu_addr_a), .cu_j(cu_j), .pc(pc), .busy(busy),
    .err(err), .retired(retired)
  );

  nand_cpu_sequencer #(.RESET_PC(16'hFFFF), .ACK_TIMEOUT(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(w_rom_addr), .rom_data(rom_data),
    .ram(w_ram_if), .cu_I(w_cu_I), .cu_A(w_cu_A), .cu_D(w_cu_D), .cu_addrA(w_cu_addrA),
    .cu_R(cu_R), .cu_a(cu_a), .cu_d(cu_d), .cu_addr_a(cu_addr_a), .cu_j(cu_j), .pc(w_pc),
    .busy(w_busy), .err(w_err), .retired(w_retired)
  );

  always @(negedge clk) begin
    if (ram_if.ram_req) req_cyc++;
    if (busy) busy_cyc++;
    if (w_ram_if.ram_req) w_req_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cu(input logic [15:0] r, input logic a, input logic d, input logic m,
                        input logic j);
    cu_R = r; cu_a = a; cu_d = d; cu_addr_a = m; cu_j = j;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; rom_data = 16'h0000;
    set_cu(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    ram_if.ram_ack = 1'b0; ram_if.ram_rdata = 16'h0000;
    w_ram_if.ram_ack = 1'b0; w_ram_if.ram_rdata = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Leaves the core in FETCH of instr with run already dropped, so it returns to IDLE.
  task automatic issue(input logic [15:0] instr);
    rom_data = instr;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic a_instr(input logic [15:0] v);
    set_cu(v, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(v);
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else passes++;
    checks++; if (rom_addr !== 16'h0000) $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); else passes++;
    checks++; if (cu_A !== 16'h0000) $display("FAIL reset_A: got %h want 0000", cu_A); else passes++;
    checks++; if (cu_D !== 16'h0000) $display("FAIL reset_D: got %h want 0000", cu_D); else passes++;
    checks++; if (cu_I !== 16'h0000) $display("FAIL reset_I: got %h want 0000", cu_I); else passes++;
    checks++; if (cu_addrA !== 16'h0000) $display("FAIL reset_MR: got %h want 0000", cu_addrA); else passes++;
    checks++; if (retired !== 16'h0000) $display("FAIL reset_retired: got %h want 0000", retired); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (ram_if.ram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", ram_if.ram_req); else passes++;
    checks++; if (ram_if.ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", ram_if.ram_we); else passes++;
    checks++; if (ram_if.ram_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", ram_if.ram_addr); else passes++;
    checks++; if (ram_if.ram_wdata !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", ram_if.ram_wdata); else passes++;
    checks++; if (w_pc !== 16'hFFFF) $display("FAIL reset_pc_param: got %h want ffff", w_pc); else passes++;
  endtask

  task automatic test_a_load();
    int r0, b0;
    do_reset();
    r0 = req_cyc; b0 = busy_cyc;
    set_cu(16'h04D2, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(16'h04D2);
    checks++; if (busy !== 1'b1) $display("FAIL aload_busy_fetch: got %b want 1", busy); else passes++;
    tick();
    checks++; if (cu_I !== 16'h04D2) $display("FAIL aload_ir: got %h want 04d2", cu_I); else passes++;
    checks++; if (cu_A !== 16'h0000) $display("FAIL aload_A_early: got %h want 0000", cu_A); else passes++;
    tick();
    checks++; if (cu_A !== 16'h04D2) $display("FAIL aload_A: got %h want 04d2", cu_A); else passes++;
    checks++; if (pc !== 16'h0001) $display("FAIL aload_pc: got %h want 0001", pc); else passes++;
    checks++; if (rom_addr !== 16'h0001) $display("FAIL aload_rom_addr: got %h want 0001", rom_addr); else passes++;
    checks++; if (retired !== 16'h0001) $display("FAIL aload_retired: got %h want 0001", retired); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL aload_idle: got %b want 0", busy); else passes++;
    checks++; if (req_cyc - r0 !== 0) $display("FAIL aload_no_req: got %0d want 0", req_cyc - r0); else passes++;
    checks++; if (busy_cyc - b0 !== 2) $display("FAIL aload_latency: got %0d want 2", busy_cyc - b0); else passes++;
  endtask

  task automatic test_compute_read();
    int r0, b0;
    do_reset();
    a_instr(16'h0007);
    set_cu(16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(16'h0009);
    tick();
    tick();
    checks++; if (cu_D !== 16'h0009) $display("FAIL read_setup_D: got %h want 0009", cu_D); else passes++;
    r0 = req_cyc; b0 = busy_cyc;
    set_cu(16'h0016, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(16'hE590);
    tick();
    checks++; if (ram_if.ram_req !== 1'b1) $display("FAIL read_req: got %b want 1", ram_if.ram_req); else passes++;
    checks++; if (ram_if.ram_we !== 1'b0) $display("FAIL read_we: got %b want 0", ram_if.ram_we); else passes++;
    checks++; if (ram_if.ram_addr !== 16'h0007) $display("FAIL read_addr: got %h want 0007", ram_if.ram_addr); else passes++;
    tick();
    tick();
    tick();
    checks++; if (ram_if.ram_req !== 1'b1) $display("FAIL read_req_held: got %b want 1", ram_if.ram_req); else passes++;
    ram_if.ram_rdata = 16'h000D;
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    ram_if.ram_rdata = 16'h0000;
    checks++; if (ram_if.ram_req !== 1'b0) $display("FAIL read_req_drop: got %b want 0", ram_if.ram_req); else passes++;
    checks++; if (cu_addrA !== 16'h000D) $display("FAIL read_mr: got %h want 000d", cu_addrA); else passes++;
    checks++; if (cu_I !== 16'hE590) $display("FAIL read_ir: got %h want e590", cu_I); else passes++;
    tick();
    checks++; if (cu_D !== 16'h0016) $display("FAIL read_D: got %h want 0016", cu_D); else passes++;
    checks++; if (cu_A !== 16'h0007) $display("FAIL read_A_kept: got %h want 0007", cu_A); else passes++;
    checks++; if (pc !== 16'h0003) $display("FAIL read_pc: got %h want 0003", pc); else passes++;
    checks++; if (retired !== 16'h0003) $display("FAIL read_retired: got %h want 0003", retired); else passes++;
    checks++; if (req_cyc - r0 !== 4) $display("FAIL read_req_cycles: got %0d want 4", req_cyc - r0); else passes++;
    checks++; if (busy_cyc - b0 !== 6) $display("FAIL read_busy_cycles: got %0d want 6", busy_cyc - b0); else passes++;
  endtask

  task automatic test_store_jump();
    int r0, b0;
    do_reset();
    a_instr(16'h002A);
    r0 = req_cyc; b0 = busy_cyc;
    set_cu(16'h0003, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(16'hE308);
    tick();
    tick();
    ram_if.ram_rdata = 16'h1234;
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    tick();
    checks++; if (ram_if.ram_req !== 1'b1) $display("FAIL store_req: got %b want 1", ram_if.ram_req); else passes++;
    checks++; if (ram_if.ram_we !== 1'b1) $display("FAIL store_we: got %b want 1", ram_if.ram_we); else passes++;
    checks++; if (ram_if.ram_addr !== 16'h002A) $display("FAIL store_addr: got %h want 002a", ram_if.ram_addr); else passes++;
    checks++; if (ram_if.ram_wdata !== 16'h0003) $display("FAIL store_wdata: got %h want 0003", ram_if.ram_wdata); else passes++;
    checks++; if (cu_A !== 16'h002A) $display("FAIL store_A_early: got %h want 002a", cu_A); else passes++;
    checks++; if (pc !== 16'h0001) $display("FAIL store_pc_early: got %h want 0001", pc); else passes++;
    // Control-unit outputs change after EXEC; the commit must use the latched ones.
    set_cu(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    checks++; if (cu_A !== 16'h0003) $display("FAIL store_A: got %h want 0003", cu_A); else passes++;
    checks++; if (cu_D !== 16'h0000) $display("FAIL store_D: got %h want 0000", cu_D); else passes++;
    checks++; if (pc !== 16'h002A) $display("FAIL store_jump_pc: got %h want 002a", pc); else passes++;
    checks++; if (retired !== 16'h0002) $display("FAIL store_retired: got %h want 0002", retired); else passes++;
    checks++; if (cu_addrA !== 16'h1234) $display("FAIL store_mr: got %h want 1234", cu_addrA); else passes++;
    checks++; if (ram_if.ram_req !== 1'b0) $display("FAIL store_req_drop: got %b want 0", ram_if.ram_req); else passes++;
    checks++; if (req_cyc - r0 !== 4) $display("FAIL store_req_cycles: got %0d want 4", req_cyc - r0); else passes++;
    checks++; if (busy_cyc - b0 !== 6) $display("FAIL store_busy_cycles: got %0d want 6", busy_cyc - b0); else passes++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    checks++; if (w_rom_addr !== 16'hFFFF) $display("FAIL wrap_rom_addr: got %h want ffff", w_rom_addr); else passes++;
    a_instr(16'h0005);
    checks++; if (w_pc !== 16'h0000) $display("FAIL wrap_pc: got %h want 0000", w_pc); else passes++;
    checks++; if (w_retired !== 16'h0001) $display("FAIL wrap_retired: got %h want 0001", w_retired); else passes++;
    checks++; if (w_cu_A !== 16'h0005) $display("FAIL wrap_A: got %h want 0005", w_cu_A); else passes++;
  endtask

  task automatic test_timeout();
    int r0;
    do_reset();
    a_instr(16'h0005);
    r0 = w_req_cyc;
    set_cu(16'h5555, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(16'h8000);
    tick();
    checks++; if (w_ram_if.ram_req !== 1'b1) $display("FAIL tmo_req: got %b want 1", w_ram_if.ram_req); else passes++;
    checks++; if (w_ram_if.ram_addr !== 16'h0005) $display("FAIL tmo_addr: got %h want 0005", w_ram_if.ram_addr); else passes++;
    tick();
    tick();
    tick();
    checks++; if (w_err !== 1'b0) $display("FAIL tmo_err_early: got %b want 0", w_err); else passes++;
    checks++; if (w_ram_if.ram_req !== 1'b1) $display("FAIL tmo_req_c4: got %b want 1", w_ram_if.ram_req); else passes++;
    tick();
    checks++; if (w_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", w_err); else passes++;
    checks++; if (w_ram_if.ram_req !== 1'b0) $display("FAIL tmo_req_drop: got %b want 0", w_ram_if.ram_req); else passes++;
    checks++; if (w_busy !== 1'b0) $display("FAIL tmo_busy: got %b want 0", w_busy); else passes++;
    checks++; if (w_cu_A !== 16'h0005) $display("FAIL tmo_A: got %h want 0005", w_cu_A); else passes++;
    checks++; if (w_cu_D !== 16'h0000) $display("FAIL tmo_D: got %h want 0000", w_cu_D); else passes++;
    checks++; if (w_pc !== 16'h0000) $display("FAIL tmo_pc: got %h want 0000", w_pc); else passes++;
    checks++; if (w_retired !== 16'h0001) $display("FAIL tmo_retired: got %h want 0001", w_retired); else passes++;
    checks++; if (w_req_cyc - r0 !== 4) $display("FAIL tmo_req_cycles: got %0d want 4", w_req_cyc - r0); else passes++;
    run = 1'b1;
    w_ram_if.ram_ack = 1'b1;
    tick();
    w_ram_if.ram_ack = 1'b0;
    tick();
    tick();
    run = 1'b0;
    checks++; if (w_err !== 1'b1) $display("FAIL tmo_sticky_err: got %b want 1", w_err); else passes++;
    checks++; if (w_busy !== 1'b0) $display("FAIL tmo_halt_busy: got %b want 0", w_busy); else passes++;
    checks++; if (w_pc !== 16'h0000) $display("FAIL tmo_halt_pc: got %h want 0000", w_pc); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (w_err !== 1'b0) $display("FAIL tmo_rst_err: got %b want 0", w_err); else passes++;
    checks++; if (w_pc !== 16'hFFFF) $display("FAIL tmo_rst_pc: got %h want ffff", w_pc); else passes++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_run_drop();
    do_reset();
    a_instr(16'h0010);
    set_cu(16'h0077, 1'b0, 1'b0, 1'b1, 1'b0);
    rom_data = 16'h8008;
    run = 1'b1;
    tick();
    tick();
    ram_if.ram_rdata = 16'h0042;
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    tick();
    run = 1'b0;
    checks++; if (ram_if.ram_we !== 1'b1) $display("FAIL drop_we: got %b want 1", ram_if.ram_we); else passes++;
    checks++; if (ram_if.ram_addr !== 16'h0010) $display("FAIL drop_addr: got %h want 0010", ram_if.ram_addr); else passes++;
    checks++; if (ram_if.ram_wdata !== 16'h0077) $display("FAIL drop_wdata: got %h want 0077", ram_if.ram_wdata); else passes++;
    tick();
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL drop_busy_wait: got %b want 1", busy); else passes++;
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL drop_idle: got %b want 0", busy); else passes++;
    checks++; if (pc !== 16'h0002) $display("FAIL drop_pc: got %h want 0002", pc); else passes++;
    checks++; if (retired !== 16'h0002) $display("FAIL drop_retired: got %h want 0002", retired); else passes++;
    checks++; if (cu_addrA !== 16'h0042) $display("FAIL drop_mr: got %h want 0042", cu_addrA); else passes++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL drop_stay_idle: got %b want 0", busy); else passes++;
    checks++; if (pc !== 16'h0002) $display("FAIL drop_pc_hold: got %h want 0002", pc); else passes++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    a_instr(16'h0003);
    checks++; if (pc !== 16'h0001) $display("FAIL rstrd_pc_before: got %h want 0001", pc); else passes++;
    issue(16'h8000);
    tick();
    checks++; if (ram_if.ram_req !== 1'b1) $display("FAIL rstrd_req: got %b want 1", ram_if.ram_req); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (ram_if.ram_req !== 1'b0) $display("FAIL rstrd_req_drop: got %b want 0", ram_if.ram_req); else passes++;
    checks++; if (pc !== 16'h0000) $display("FAIL rstrd_pc: got %h want 0000", pc); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rstrd_busy: got %b want 0", busy); else passes++;
    checks++; if (cu_A !== 16'h0000) $display("FAIL rstrd_A: got %h want 0000", cu_A); else passes++;
    checks++; if (retired !== 16'h0000) $display("FAIL rstrd_retired: got %h want 0000", retired); else passes++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_a_load();
    test_compute_read();
    test_store_jump();
    test_pc_wrap();
    test_timeout();
    test_run_drop();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nand_cpu_sequencer.md
Name: nand_cpu_sequencer

Overview:
- Multi-cycle state/sequencing half of the Nandgame CPU. It owns the A, D and PC registers, fetches instructions from ROM and reads RAM at A.
- It presents I/A/D/*A to the external combinational control unit, then consumes that unit's R, a, d, addr_a and j outputs to commit results.
- RAM is reached through a req/ack handshake, so slow memories stall the core.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
ACK_TIMEOUT, 255, maximum cycles to wait for ram_ack before error (1..65535).

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute instructions, 0 = stop after current instruction
rom_addr  out  16  instruction address (= pc)
rom_data  in  16  instruction word, combinational from rom_addr
ram_req  out  1  RAM transaction request
ram_we  out  1  1 = write, 0 = read; valid while ram_req
ram_addr  out  16  RAM address
ram_wdata  out  16  write data
ram_rdata  in  16  read data, sampled on the cycle ram_ack=1
ram_ack  in  1  one-cycle transaction completion
cu_I  out  16  instruction register to control unit
cu_A  out  16  A register to control unit
cu_D  out  16  D register to control unit
cu_addrA  out  16  latched RAM[A] to control unit
cu_R  in  16  control unit result
cu_a  in  1  write-A enable
cu_d  in  1  write-D enable
cu_addr_a  in  1  write-RAM[A] enable
cu_j  in  1  jump enable
pc  out  16  program counter
busy  out  1  1 when state != IDLE and != HALT
err  out  1  sticky RAM-timeout flag
retired  out  16  count of committed instructions, wraps FFFF->0000

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; A=D=IR=MR=0; retired=0; err=0.
  - ram_req=ram_we=0; ram_addr=ram_wdata=0; state=IDLE.
  - Reset mid-transaction abandons it immediately.
- States: IDLE, FETCH, READ, EXEC, WRITE, HALT.
- IDLE: run=1 -> FETCH; else stay.
- FETCH (1 cycle): IR<=rom_data.
  - If rom_data[15]=1 -> READ.
  - Else MR<=MR (unchanged) -> EXEC.
- READ:
  - ram_req=1, ram_we=0, ram_addr=A.
  - On ram_ack: MR<=ram_rdata, drop ram_req next cycle -> EXEC.
- EXEC (1 cycle): cu_* outputs are stable; sample cu_R/cu_a/cu_d/cu_addr_a/cu_j.
  - If cu_addr_a=1: Rlat<=cu_R and latch enables -> WRITE. No register updates yet.
  - Else commit.
- WRITE:
  - ram_req=1, ram_we=1, ram_addr=A (pre-update value), ram_wdata=Rlat.
  - On ram_ack -> commit using latched enables.
- Commit (same edge as leaving EXEC/WRITE):
  - A<=R if a; D<=R if d.
  - pc<= j ? old A : pc+1 (16-bit wrap, FFFF->0000).
  - retired<=retired+1.
  - Next state: FETCH if run=1, else IDLE.
  - Jump target and RAM address always use A as it was before this instruction's writes.
- cu_I=IR, cu_A=A, cu_D=D, cu_addrA=MR at all times, combinational from registers.
- Handshake:
  - ram_req rises at state entry and stays high with stable addr/we/wdata until the ack cycle.
  - Deasserted in the cycle after ack.
  - ram_ack outside READ/WRITE is ignored.
- Timeout:
  - Per-transaction counter reset at READ/WRITE entry.
  - If ACK_TIMEOUT cycles elapse without ack: err<=1, ram_req<=0, -> HALT. No commit.
- HALT: only rst_n exits; busy=0; ram_req=0.
- run deasserted mid-instruction: the instruction completes fully, then IDLE.
- Latency with zero-wait RAM (ack the cycle after req rises):
  - A-instruction: 2 cycles.
  - Compute instruction, no store: 4 cycles.
  - Compute instruction with store: 6 cycles.

Test Plan:
- Reset/A-load: rst_n pulse, run=1, rom_data=16'h04D2 -> FETCH, EXEC; A=16'h04D2, pc=1, retired=1, ram_req never asserted.
- Compute with read: A=7, D=9, rom_data=16'hE590, RAM returns 16'h000D after 3 wait cycles, bench CU drives R=16'h0016, d=1 -> ram_req high 4 cycles at addr 7, cu_addrA=000D, D=0016, pc+1.
- Store + jump ordering: A=16'h002A, bench CU drives R=16'h0003, a=1, addr_a=1, j=1 -> write addr=002A, wdata=0003; after ack A=0003 and pc=002A.
- PC wrap: RESET_PC=16'hFFFF, A-instruction -> pc=0000, retired=1.
- Timeout: ACK_TIMEOUT=4, never ack in READ -> err=1 after 4 cycles, state HALT, ram_req=0, A/D/pc unchanged; only rst_n clears.
- run drop/reset mid-op: run=0 during WRITE wait -> instruction commits then IDLE, busy=0. rst_n low during READ -> ram_req=0 immediately, pc=RESET_PC.
